// File: rtl/parity_stream_unit_if.sv
// Stream bundle for parity_stream_unit: input channel, output channel and
// error-counter sideband, with the unit's view (slave) and the source/sink view (master).
interface parity_stream_unit_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
);
    logic              mode_odd;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_par;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_par;
    logic              out_err;
    logic              out_last;
    logic              out_frame_par;
    logic              err_clr;
    logic [CNT_W-1:0]  err_count;

    modport slave (
        input  mode_odd, in_valid, in_data, in_par, in_last, out_ready, err_clr,
        output in_ready, out_valid, out_data, out_par, out_err, out_last, out_frame_par,
               err_count
    );

    modport master (
        output mode_odd, in_valid, in_data, in_par, in_last, out_ready, err_clr,
        input  in_ready, out_valid, out_data, out_par, out_err, out_last, out_frame_par,
               err_count
    );
endinterface

// File: rtl/parity_stream_unit.sv
// Pipelined per-word and per-frame parity generator/checker with a single
// registered output stage and a saturating mismatch counter.
module parity_stream_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    parity_stream_unit_if.slave   bus
);

    typedef enum logic {StIdle, StInFrame} state_e;

    state_e            r_state;
    logic              r_mode;
    logic              r_acc;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_par;
    logic              r_out_err;
    logic              r_out_last;
    logic              r_out_frame_par;
    logic [CNT_W-1:0]  r_err_count;

    logic w_ready;
    logic w_accept;
    logic w_mode;
    logic w_p;
    logic w_err;
    logic w_err_hit;

    assign w_ready   = !r_out_valid || bus.out_ready;
    assign w_accept  = bus.in_valid && w_ready;
    // Mode is taken live on a frame's first word, then frozen until its last word.
    assign w_mode    = (r_state == StInFrame) ? r_mode : bus.mode_odd;
    assign w_p       = ^bus.in_data;
    assign w_err     = w_p ^ bus.in_par ^ w_mode;
    assign w_err_hit = w_accept && w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= StIdle;
            r_mode          <= 1'b0;
            r_acc           <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_par       <= 1'b0;
            r_out_err       <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_frame_par <= 1'b0;
            r_err_count     <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid     <= 1'b1;
                r_out_data      <= bus.in_data;
                r_out_par       <= w_p ^ w_mode;
                r_out_err       <= w_err;
                r_out_last      <= bus.in_last;
                r_out_frame_par <= bus.in_last ? (r_acc ^ w_p ^ w_mode) : 1'b0;
                if (bus.in_last) begin
                    r_acc   <= 1'b0;
                    r_state <= StIdle;
                end else begin
                    r_acc <= r_acc ^ w_p;
                    if (r_state == StIdle) begin
                        r_state <= StInFrame;
                        r_mode  <= bus.mode_odd;
                    end
                end
            end else if (bus.out_ready) begin
                r_out_valid     <= 1'b0;
                r_out_frame_par <= 1'b0;
            end

            if (bus.err_clr) begin
                r_err_count <= w_err_hit ? CNT_W'(1) : '0;
            end else if (w_err_hit && (r_err_count != '1)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready      = w_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_par       = r_out_par;
    assign bus.out_err       = r_out_err;
    assign bus.out_last      = r_out_last;
    assign bus.out_frame_par = r_out_frame_par;
    assign bus.err_count     = r_err_count;

endmodule

// File: doc/parity_stream_unit.md
# parity_stream_unit

Parametrised, pipelined parity generator/checker for a valid/ready word stream. Every accepted word gets a per-word parity bit, a parity check against a supplied parity bit, and a running frame parity that is delivered on the frame's last word. Parity mode is even or odd, latched per frame. A saturating error counter is provided. The block sits in front of serial links and buffers that need per-word and per-frame parity with backpressure.

## Interface
- DATA_W, 8: data word width, at least 1.
- CNT_W, 8: error counter width, at least 1.
- clk  in  1: single clock, all state on rising edge.
- rst  in  1: asynchronous, active-high reset.
- mode_odd  in  1: parity mode. 0 = even, 1 = odd. Latched at the first word of each frame.
- in_valid  in  1: input word valid.
- in_ready  out  1: block can accept a word.
- in_data  in  DATA_W: input word.
- in_par  in  1: received parity bit to check against in_data.
- in_last  in  1: word is the last word of its frame. A single-word frame is legal.
- out_valid  out  1: output registers hold a word.
- out_ready  in  1: downstream accepts the output word.
- out_data  out  DATA_W: registered copy of the accepted word.
- out_par  out  1: generated parity for out_data.
- out_err  out  1: received parity mismatched for this word.
- out_last  out  1: registered copy of in_last.
- out_frame_par  out  1: parity of the whole frame. Valid only when out_valid and out_last are both high. 0 otherwise.
- err_clr  in  1: synchronous clear of err_count.
- err_count  out  CNT_W: saturating count of accepted words with a mismatch.

## Operation
- Acceptance: a word is accepted when in_valid and in_ready are high in the same cycle.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput with a single output stage.
- Frame FSM has two states:
  - IDLE → IN_FRAME on an accepted word with in_last = 0. mode_odd is latched into mode_q on this transition.
  - IN_FRAME → IDLE on an accepted word with in_last = 1.
  - IDLE with an accepted word that has in_last = 1 is a single-word frame. State stays IDLE.
- Effective mode m:
  - In IDLE, m = mode_odd (live value).
  - In IN_FRAME, m = mode_q. Changes on mode_odd mid-frame are ignored.
- Per-word results for an accepted word d, with p = XOR-reduce(d):
  - out_par = p ^ m.
  - out_err = p ^ in_par ^ m. This is 1 when {d, in_par} does not have the required parity.
- Frame accumulator acc (1 bit):
  - On an accepted non-last word: acc ← acc ^ p.
  - On an accepted last word: out_frame_par = acc ^ p ^ m, and acc ← 0.
- err_count update:
  - err_clr alone: count ← 0.
  - Accepted word with out_err = 1: count ← count + 1, saturating at 2^CNT_W − 1.
  - err_clr and a counted error in the same cycle: count ← 1.
- Output hold: when out_valid = 1 and out_ready = 0, all out_* signals are held stable.

## Timing
- Latency: an accepted word appears on out_* in the next cycle, with out_valid = 1.
- out_valid clears on an out_ready handshake when no new word is accepted in the same cycle.
- Simultaneous output handshake and input acceptance replaces the output contents with no bubble. Sustained rate is 1 word/cycle.
- err_count updates in the cycle after acceptance, together with out_err.
- Reset values: out_valid = 0, out_data = 0, out_par = 0, out_err = 0, out_last = 0, out_frame_par = 0, err_count = 0, state = IDLE, acc = 0, mode_q = 0.
- in_ready = 1 immediately after reset.
- Reset mid-frame discards the partial frame and any held output word. The next word starts a new frame.
- in_par is checked on every word, including the last word of a frame.

## Test plan
- Generation, DATA_W = 8:
  - even mode, 0xA5 → out_par = 0; 0xA7 → out_par = 1.
  - odd mode, 0xA5 → out_par = 1.
  - Each result appears one cycle after acceptance.
- Check: even mode, 0xA5 with in_par = 1 → out_err = 1 and err_count goes 0 → 1. Same word with in_par = 0 → out_err = 0 and the count is unchanged.
- Frame, even mode: words 0x01, 0x03, 0x07 (last) → out_frame_par = 0 on the third output. Frame 0x01, 0x02 (last) → 0. Frame 0x01 (last) → 1.
- Mode latch: start a frame in even mode, set mode_odd = 1 after the first word; frame 0x01, 0x01 (last) → out_par = 1, 1 and out_frame_par = 0. The next frame uses odd mode.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles with in_valid high → in_ready = 0 and out_data stays stable.
  - Release → words delivered in order, none lost or duplicated.
  - Reset asserted mid-frame → out_valid = 0 and the following frame's parity is correct.
- Counter, CNT_W = 2:
  - 5 erroneous words → err_count = 3 (saturated).
  - err_clr together with an erroneous word → err_count = 1.
  - err_clr alone → err_count = 0.
